// File: rtl/trap_ctrl_if.sv
// CSR register-file port shared by the trap controller and the CSR file.
//   master (trap_ctrl): drives csr_w / csr_addr / csr_wdata, reads csr_rdata
//   slave  (CSR file) : accepts the write/address, returns combinational csr_rdata
interface trap_ctrl_if;
  logic        csr_w;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  modport master (
    output csr_w,
    output csr_addr,
    output csr_wdata,
    input  csr_rdata
  );

  modport slave (
    input  csr_w,
    input  csr_addr,
    input  csr_wdata,
    output csr_rdata
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap controller: hardware-side master of the CSR register-file port.
// Sequences trap entry (mepc, mcause, mstatus writes, mtvec read + redirect)
// and mret (mstatus restore, mepc read + redirect). While idle it forwards the
// instruction-driven CSR access straight to the CSR file.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   exc_req_i           one-cycle exception pulse (sampled only when idle)
//   exc_cause_i[3:0]    exception code, zero-extended into mcause
//   mret_req_i          one-cycle mret pulse (sampled only when idle)
//   irq_i               external interrupt level, gated by shadow MIE
//   trap_pc_i[31:0]     PC to save into mepc
//   cpu_csr_w_i, cpu_csr_addr_i[11:0], cpu_csr_wdata_i[31:0]
//                       instruction CSR access, forwarded only when idle
//   csr (master)        CSR file port
//   busy_o              high in every non-idle state
//   redirect_valid_o    one-cycle pulse, fetch jumps to redirect_pc_o
//   redirect_pc_o[31:0] word-aligned target PC, held between pulses
module trap_ctrl #(
  parameter logic [11:0] ADDR_MSTATUS = 12'h000,
  parameter logic [11:0] ADDR_MEPC    = 12'h041,
  parameter logic [11:0] ADDR_MCAUSE  = 12'h042,
  parameter logic [11:0] ADDR_MTVEC   = 12'h005,
  parameter logic [31:0] IRQ_CAUSE    = 32'h8000000B
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exc_req_i,
  input  logic [3:0]          exc_cause_i,
  input  logic                mret_req_i,
  input  logic                irq_i,
  input  logic [31:0]         trap_pc_i,
  input  logic                cpu_csr_w_i,
  input  logic [11:0]         cpu_csr_addr_i,
  input  logic [31:0]         cpu_csr_wdata_i,
  trap_ctrl_if.master         csr,
  output logic                busy_o,
  output logic                redirect_valid_o,
  output logic [31:0]         redirect_pc_o
);

  typedef enum logic [2:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
    T_STAT,
    T_VEC,
    R_STAT,
    R_EPC
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic        mie_q, mie_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        csr_w_c;
  logic [11:0] csr_addr_c;
  logic [31:0] csr_wdata_c;

  // Trap entry: MPIE <= MIE, MIE <= 0, all other bits preserved.
  function automatic logic [31:0] mstatus_trap(input logic [31:0] v);
    logic [31:0] r;
    r    = v;
    r[7] = v[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // mret: MIE <= MPIE, MPIE <= 1, all other bits preserved.
  function automatic logic [31:0] mstatus_mret(input logic [31:0] v);
    logic [31:0] r;
    r    = v;
    r[3] = v[7];
    r[7] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] v);
    return v & ~32'h3;
  endfunction

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    cause_d          = cause_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    csr_w_c          = 1'b0;
    csr_addr_c       = '0;
    csr_wdata_c      = '0;

    case (state_q)
      IDLE: begin
        csr_w_c     = cpu_csr_w_i;
        csr_addr_c  = cpu_csr_addr_i;
        csr_wdata_c = cpu_csr_wdata_i;
        // Priority: exception > enabled interrupt > mret; losers are dropped.
        if (exc_req_i) begin
          state_d = T_EPC;
          pc_d    = trap_pc_i;
          cause_d = {28'b0, exc_cause_i};
        end else if (irq_i && mie_q) begin
          state_d = T_EPC;
          pc_d    = trap_pc_i;
          cause_d = IRQ_CAUSE;
        end else if (mret_req_i) begin
          state_d = R_STAT;
          pc_d    = trap_pc_i;
        end
      end
      T_EPC: begin
        csr_w_c     = 1'b1;
        csr_addr_c  = ADDR_MEPC;
        csr_wdata_c = pc_q;
        state_d     = T_CAUSE;
      end
      T_CAUSE: begin
        csr_w_c     = 1'b1;
        csr_addr_c  = ADDR_MCAUSE;
        csr_wdata_c = cause_q;
        state_d     = T_STAT;
      end
      T_STAT: begin
        csr_w_c     = 1'b1;
        csr_addr_c  = ADDR_MSTATUS;
        csr_wdata_c = mstatus_trap(csr.csr_rdata);
        state_d     = T_VEC;
      end
      T_VEC: begin
        csr_addr_c       = ADDR_MTVEC;
        redirect_pc_d    = word_align(csr.csr_rdata);
        redirect_valid_d = 1'b1;
        state_d          = IDLE;
      end
      R_STAT: begin
        csr_w_c     = 1'b1;
        csr_addr_c  = ADDR_MSTATUS;
        csr_wdata_c = mstatus_mret(csr.csr_rdata);
        state_d     = R_EPC;
      end
      R_EPC: begin
        csr_addr_c       = ADDR_MEPC;
        redirect_pc_d    = word_align(csr.csr_rdata);
        redirect_valid_d = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A reset cycle must not let an in-flight sequence land one more write.
    if (rst) csr_w_c = 1'b0;

    // Shadow MIE follows every write to mstatus, whoever issues it.
    mie_d = mie_q;
    if (csr_w_c && (csr_addr_c == ADDR_MSTATUS)) mie_d = csr_wdata_c[3];
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      mie_q            <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      mie_q            <= mie_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // Latched request data; only meaningful after acceptance
  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    cause_q <= cause_d;
  end

  assign csr.csr_w         = csr_w_c;
  assign csr.csr_addr      = csr_addr_c;
  assign csr.csr_wdata     = csr_wdata_c;
  assign busy_o            = (state_q != IDLE);
  assign redirect_valid_o  = redirect_valid_q;
  assign redirect_pc_o     = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: a CSR-file model on the interface, a passthrough vector
// table, hand-written trap/mret/irq/reset sequences, and a randomized phase
// checked against a transaction-level reference model.
module tb_trap_ctrl;
  localparam logic [11:0] A_MSTATUS = 12'h000;
  localparam logic [11:0] A_MEPC    = 12'h041;
  localparam logic [11:0] A_MCAUSE  = 12'h042;
  localparam logic [11:0] A_MTVEC   = 12'h005;
  localparam logic [31:0] IRQ_C     = 32'h8000000B;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_req;
  logic [3:0]  exc_cause;
  logic        mret_req;
  logic        irq;
  logic [31:0] trap_pc;
  logic        cpu_w;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        busy;
  logic        rv;
  logic [31:0] rpc;
  logic        clr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trap_ctrl_if csr_if ();

  // CSR file model: combinational read, write at posedge, bulk clear.
  logic [31:0] csrf [0:4095];
  assign csr_if.csr_rdata = csrf[csr_if.csr_addr];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) csrf[i] <= 32'h0;
    end else if (csr_if.csr_w) begin
      csrf[csr_if.csr_addr] <= csr_if.csr_wdata;
    end
  end

  trap_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .exc_req_i        (exc_req),
    .exc_cause_i      (exc_cause),
    .mret_req_i       (mret_req),
    .irq_i            (irq),
    .trap_pc_i        (trap_pc),
    .cpu_csr_w_i      (cpu_w),
    .cpu_csr_addr_i   (cpu_addr),
    .cpu_csr_wdata_i  (cpu_wdata),
    .csr              (csr_if.master),
    .busy_o           (busy),
    .redirect_valid_o (rv),
    .redirect_pc_o    (rpc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [11:0] a, input logic [31:0] d);
    cpu_w = 1'b1; cpu_addr = a; cpu_wdata = d;
    tick();
    cpu_w = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [11:0] a;
    logic [31:0] d;
    logic        exp_w;
    logic [11:0] exp_a;
    logic [31:0] exp_d;
    logic [31:0] exp_land;
  } pt_vec_t;

  pt_vec_t vec [4];

  // Reference model state for the random phase
  logic [31:0] mdl [0:4095];
  logic        m_mie;
  int          left;
  logic        exp_rv;
  logic [31:0] exp_pc;
  logic [31:0] target;

  function automatic logic [11:0] pick_addr(input int i);
    case (i)
      0:       return A_MSTATUS;
      1:       return A_MEPC;
      2:       return A_MCAUSE;
      3:       return A_MTVEC;
      default: return 12'h010;
    endcase
  endfunction

  function automatic logic [3:0] pick_cause(input int i);
    case (i)
      0:       return 4'd2;
      1:       return 4'd3;
      default: return 4'd11;
    endcase
  endfunction

  task automatic m_trap(input logic [31:0] pc, input logic [31:0] cause);
    logic [31:0] ms;
    mdl[A_MEPC]   = pc;
    mdl[A_MCAUSE] = cause;
    ms = mdl[A_MSTATUS];
    mdl[A_MSTATUS] = (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0);
    m_mie  = 1'b0;
    target = mdl[A_MTVEC] & ~32'h3;
    left   = 4;
  endtask

  task automatic m_mret();
    logic [31:0] ms;
    ms = mdl[A_MSTATUS];
    mdl[A_MSTATUS] = (ms & ~32'h88) | 32'h80 | (ms[7] ? 32'h08 : 32'h0);
    m_mie  = ms[7];
    target = mdl[A_MEPC] & ~32'h3;
    left   = 2;
  endtask

  int rv_cnt;
  int busy_cnt;

  initial begin
    rst = 1'b1; clr = 1'b1;
    exc_req = 0; exc_cause = 0; mret_req = 0; irq = 0; trap_pc = 0;
    cpu_w = 0; cpu_addr = 0; cpu_wdata = 0;
    tick(); tick();
    rst = 1'b0; clr = 1'b0;

    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_rv", {31'b0, rv}, 32'h0);
    chk("reset_rpc", rpc, 32'h0);
    chk("reset_csr_w", {31'b0, csr_if.csr_w}, 32'h0);

    // Passthrough vectors in idle
    vec[0] = '{1'b1, 12'h010, 32'h12345678, 1'b1, 12'h010, 32'h12345678, 32'h12345678};
    vec[1] = '{1'b0, 12'h011, 32'hFFFFFFFF, 1'b0, 12'h011, 32'hFFFFFFFF, 32'h00000000};
    vec[2] = '{1'b1, 12'h005, 32'h00000103, 1'b1, 12'h005, 32'h00000103, 32'h00000103};
    vec[3] = '{1'b1, 12'h000, 32'h00000008, 1'b1, 12'h000, 32'h00000008, 32'h00000008};
    for (int i = 0; i < 4; i++) begin
      cpu_w = vec[i].w; cpu_addr = vec[i].a; cpu_wdata = vec[i].d;
      #1;
      chk("pt_w", {31'b0, csr_if.csr_w}, {31'b0, vec[i].exp_w});
      chk("pt_addr", {20'b0, csr_if.csr_addr}, {20'b0, vec[i].exp_a});
      chk("pt_wdata", csr_if.csr_wdata, vec[i].exp_d);
      tick();
      cpu_w = 1'b0;
      chk("pt_land", csrf[vec[i].a], vec[i].exp_land);
    end

    // ecall: trap latency and CSR effects
    exc_req = 1; exc_cause = 4'd11; trap_pc = 32'h40;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exc_req = 0;
      if (k < 5) begin
        chk("ecall_busy", {31'b0, busy}, 32'h1);
        chk("ecall_rv_early", {31'b0, rv}, 32'h0);
      end else begin
        chk("ecall_busy_done", {31'b0, busy}, 32'h0);
        chk("ecall_rv", {31'b0, rv}, 32'h1);
        chk("ecall_rpc", rpc, 32'h100);
      end
    end
    chk("ecall_mepc", csrf[A_MEPC], 32'h40);
    chk("ecall_mcause", csrf[A_MCAUSE], 32'hB);
    chk("ecall_mstatus", csrf[A_MSTATUS], 32'h80);
    tick();
    chk("ecall_rv_single", {31'b0, rv}, 32'h0);
    chk("ecall_rpc_hold", rpc, 32'h100);

    // mret
    mret_req = 1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      mret_req = 0;
      if (k < 3) begin
        chk("mret_busy", {31'b0, busy}, 32'h1);
        chk("mret_rv_early", {31'b0, rv}, 32'h0);
      end else begin
        chk("mret_busy_done", {31'b0, busy}, 32'h0);
        chk("mret_rv", {31'b0, rv}, 32'h1);
        chk("mret_rpc", rpc, 32'h40);
      end
    end
    chk("mret_mstatus", csrf[A_MSTATUS], 32'h88);

    // irq masked, then enabled by a software write, then held without re-trap
    cpu_wr(A_MSTATUS, 32'h0);
    irq = 1; trap_pc = 32'h200;
    busy_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (busy) busy_cnt++;
    end
    chk("irq_masked", busy_cnt, 0);
    cpu_wr(A_MSTATUS, 32'h08);
    chk("irq_not_yet", {31'b0, busy}, 32'h0);
    tick();
    chk("irq_taken", {31'b0, busy}, 32'h1);
    tick(); tick(); tick();
    chk("irq_busy_last", {31'b0, busy}, 32'h1);
    tick();
    chk("irq_rv", {31'b0, rv}, 32'h1);
    chk("irq_rpc", rpc, 32'h100);
    chk("irq_mcause", csrf[A_MCAUSE], IRQ_C);
    chk("irq_mepc", csrf[A_MEPC], 32'h200);
    chk("irq_mstatus", csrf[A_MSTATUS], 32'h80);
    busy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (busy) busy_cnt++;
    end
    chk("irq_no_retrap", busy_cnt, 0);
    irq = 0;

    // Simultaneous exception, enabled irq and mret
    cpu_wr(A_MSTATUS, 32'h08);
    exc_req = 1; exc_cause = 4'd2; irq = 1; mret_req = 1; trap_pc = 32'h300;
    tick();
    exc_req = 0; irq = 0; mret_req = 0;
    rv_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rv) rv_cnt++;
    end
    chk("prio_one_redirect", rv_cnt, 1);
    chk("prio_mcause", csrf[A_MCAUSE], 32'h2);
    chk("prio_mepc", csrf[A_MEPC], 32'h300);
    chk("prio_mstatus", csrf[A_MSTATUS], 32'h80);

    // CPU writes while busy never reach the CSR file
    exc_req = 1; exc_cause = 4'd11; trap_pc = 32'h500;
    tick();
    exc_req = 0;
    cpu_w = 1; cpu_addr = 12'h020; cpu_wdata = 32'hDEADBEEF;
    #1;
    chk("busy_own_addr", {20'b0, csr_if.csr_addr}, {20'b0, A_MEPC});
    chk("busy_own_wdata", csr_if.csr_wdata, 32'h500);
    tick(); tick(); tick();
    chk("busy_no_write", csrf[12'h020], 32'h0);
    cpu_w = 0;
    tick();
    cpu_w = 1;
    #1;
    chk("idle_pass_w", {31'b0, csr_if.csr_w}, 32'h1);
    tick();
    cpu_w = 0;
    chk("idle_write_lands", csrf[12'h020], 32'hDEADBEEF);

    // Reset in the middle of trap entry
    exc_req = 1; exc_cause = 4'd3; trap_pc = 32'h600;
    tick();
    exc_req = 0;
    tick();
    rst = 1;
    #1;
    chk("rst_gates_w", {31'b0, csr_if.csr_w}, 32'h0);
    tick();
    rst = 0;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_rv", {31'b0, rv}, 32'h0);
    chk("rst_csr_w", {31'b0, csr_if.csr_w}, 32'h0);
    chk("rst_mcause", csrf[A_MCAUSE], 32'hB);
    chk("rst_mepc", csrf[A_MEPC], 32'h600);
    busy_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (busy || rv) busy_cnt++;
    end
    chk("rst_stays_idle", busy_cnt, 0);

    // Randomized phase against the reference model
    rst = 1; clr = 1;
    tick(); tick();
    rst = 0; clr = 0;
    for (int i = 0; i < 4096; i++) mdl[i] = 32'h0;
    m_mie = 0; left = 0; exp_rv = 0; exp_pc = 32'h0; target = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic       e, m, q, w, old_mie, next_rv;
      logic [3:0] c;
      logic [11:0] a;
      logic [31:0] d, p;
      chk("rnd_busy", {31'b0, busy}, (left > 0) ? 32'h1 : 32'h0);
      chk("rnd_rv", {31'b0, rv}, {31'b0, exp_rv});
      chk("rnd_rpc", rpc, exp_pc);
      if (left == 0) begin
        for (int j = 0; j < 5; j++) chk("rnd_csr", csrf[pick_addr(j)], mdl[pick_addr(j)]);
      end
      e = ($urandom_range(0, 7) == 0);
      m = ($urandom_range(0, 5) == 0);
      q = ($urandom_range(0, 3) == 0);
      w = ($urandom_range(0, 2) == 0);
      c = pick_cause($urandom_range(0, 2));
      a = pick_addr($urandom_range(0, 4));
      d = $urandom;
      p = $urandom;
      exc_req = e; exc_cause = c; mret_req = m; irq = q; trap_pc = p;
      cpu_w = w; cpu_addr = a; cpu_wdata = d;
      next_rv = 1'b0;
      if (left == 0) begin
        old_mie = m_mie;
        if (w) begin
          mdl[a] = d;
          if (a == A_MSTATUS) m_mie = d[3];
        end
        if (e) m_trap(p, {28'b0, c});
        else if (q && old_mie) m_trap(p, IRQ_C);
        else if (m) m_mret();
      end else begin
        if (left == 1) begin
          next_rv = 1'b1;
          exp_pc  = target;
        end
        left--;
      end
      exp_rv = next_rv;
      tick();
    end
    exc_req = 0; mret_req = 0; irq = 0; cpu_w = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Hardware-side master of the CSR register file port.
- On a synchronous exception (ecall/ebreak/illegal) or an enabled external interrupt, it sequences the trap-entry writes (mepc, mcause, mstatus), then reads mtvec and redirects the PC.
- On mret it restores mstatus, reads mepc and redirects.
- When idle, it passes the instruction-driven CSR access (csrrw/csrrwi) straight through to the CSR file, so it sits between decode/execute and the CSR file.

Parameters:
- ADDR_MSTATUS, 12'h000, CSR address of mstatus
- ADDR_MEPC, 12'h041, CSR address of mepc
- ADDR_MCAUSE, 12'h042, CSR address of mcause
- ADDR_MTVEC, 12'h005, CSR address of mtvec
- IRQ_CAUSE, 32'h8000000B, mcause value written for an external interrupt

Ports:
- clk  in  1  system clock; one clock, all state on posedge
- rst  in  1  reset, synchronous, active-high
- exc_req  in  1  one-cycle exception pulse from decode; sampled only while busy=0
- exc_cause  in  4  exception code (2 illegal, 3 ebreak, 11 ecall), zero-extended into mcause
- mret_req  in  1  one-cycle mret pulse; sampled only while busy=0
- irq  in  1  external interrupt, level
- trap_pc  in  32  PC saved to mepc (faulting instr for exceptions, next instr for irq)
- cpu_csr_w  in  1  instruction CSR write enable
- cpu_csr_addr  in  12  instruction CSR address
- cpu_csr_wdata  in  32  instruction CSR write data
- csr_w  out  1  write enable to CSR file
- csr_addr  out  12  address to CSR file
- csr_wdata  out  32  write data to CSR file
- csr_rdata  in  32  combinational read data from CSR file (write takes effect at posedge)
- busy  out  1  high in every non-IDLE state; pipeline stalls
- redirect_valid  out  1  one-cycle pulse: fetch must jump to redirect_pc
- redirect_pc  out  32  target PC, word-aligned

Behaviour:
- Reset puts FSM in IDLE and drives busy=0, redirect_valid=0, redirect_pc=0, internal mie_q=0, csr_w=0. Reset mid-sequence abandons it with no further CSR writes.
- IDLE: csr_w/csr_addr/csr_wdata = cpu_csr_*.
- Non-IDLE: cpu_csr_* are ignored and the FSM owns the port.
- mie_q shadows mstatus bit 3 (MIE). It updates on any posedge write to ADDR_MSTATUS, from either passthrough or FSM: mie_q <= written data bit 3.
- Acceptance in IDLE uses priority exc_req > (irq & mie_q) > mret_req. Lower-priority pulses in the same cycle are dropped. Requests while busy=1 are ignored.
- On acceptance, latch trap_pc. Latch cause as {28'b0, exc_cause} for an exception or IRQ_CAUSE for an interrupt.
- Trap path, one state per cycle:
  - T_EPC: write mepc = latched pc.
  - T_CAUSE: write mcause = latched cause.
  - T_STAT: addr=mstatus; write rdata with bit7 (MPIE) = rdata bit3 and bit3 (MIE) = 0.
  - T_VEC: addr=mtvec, no write; redirect_pc <= {rdata[31:2],2'b00}; next IDLE with redirect_valid=1 for that one cycle.
- mret path:
  - R_STAT: RMW mstatus with bit3 = rdata bit7 and bit7 = 1.
  - R_EPC: addr=mepc, no write; redirect_pc <= {rdata[31:2],2'b00}; next IDLE with redirect_valid=1.
- Latency:
  - Trap: request at cycle N gives busy=1 for N+1..N+4 and redirect_valid at N+5.
  - mret: busy N+1..N+2, redirect_valid at N+3.
- redirect_valid is never high for two consecutive cycles. redirect_pc holds its value between pulses.
- A request may be accepted in the same IDLE cycle that redirect_valid is high.
- After trap entry mie_q=0, so irq is masked until mret or a software write sets MIE. A level irq held through a handler does not re-trap.
- All bits of mstatus other than 3 and 7 are preserved by both RMW states.

Test Plan:
- mtvec=0x00000103 via passthrough; ecall pulse (cause 11, trap_pc=0x40): mepc=0x40, mcause=0x0000000B, mstatus 0x08 becomes 0x80; redirect_valid only at N+5 with redirect_pc=0x100.
- After the above, mret pulse: mstatus 0x80 becomes 0x88; redirect_pc=0x40 at N+3; busy high exactly 2 cycles.
- irq=1 with mstatus=0: no trap. Write mstatus=0x08: next cycle trap with mcause=0x8000000B. irq held high afterwards: no second trap.
- exc_req, irq (enabled) and mret_req in the same cycle: exception taken with mcause = exc_cause. mret has no effect; exactly one redirect.
- cpu_csr_w pulses during busy: no write reaches the CSR file; the same write in IDLE lands at the next posedge.
- rst asserted during T_CAUSE: next cycle busy=0, redirect_valid=0, csr_w=0. mcause is unchanged, mepc keeps the new value.
